pc_ir_fetch_unit: RTL
=====================

# pc_ir_fetch_unit

- Holds the program counter (PC), instruction register (IR), fetched-instruction address (IA) and the registered condition flags.
- Sits directly upstream of the LEGv8 control unit:
  - It feeds the control unit `instruction` and `status`.
  - It consumes the control unit's PS, PCsel, IL and SL fields and its `constant`.
- Handles the instruction-memory ready handshake and asserts `stall`, which freezes the control-unit state register.
- Reports misaligned branch targets and counts retired fetches.

## Interface
- `RESET_PC`, 64'h0, PC value after reset; bits [1:0] must be 0.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `PS`  in  2  PC function:
  - 00: hold.
  - 01: PC+4.
  - 1x: load branch target.
- `PCsel`  in  1  branch target source: 0 = `in` (register), 1 = IA + (`constant` << 2).
- `IL`  in  1  instruction load request (fetch).
- `SL`  in  1  status load.
- `in`  in  64  register/bus value, used for BR/BLR/RET targets.
- `constant`  in  64  sign-extended word offset from the constant generator.
- `imem_data`  in  32  instruction word at `imem_addr`.
- `imem_ready`  in  1  `imem_data` valid this cycle.
- `alu_flags`  in  4  live ALU {V,C,N,Z}.
- `imem_addr`  out  64  equals PC.
- `instruction`  out  32  IR.
- `status`  out  5  {V_r, C_r, N_r, Z_r, Z_live}; bit 0 is the unregistered ALU Z (used for CBZ/CBNZ).
- `PC4`  out  64  IA + 4 (BL link value).
- `stall`  out  1  fetch waiting on memory.
- `align_fault`  out  1  sticky misaligned-target flag.
- `fetch_count`  out  32  number of completed fetches.

## Operation
- Fetch occurs when `IL`=1:
  - If `imem_ready`=1: IR <- `imem_data`, IA <- PC, `fetch_count` +1, and the PC action given by PS is applied (normally 01).
  - If `imem_ready`=0: `stall`=1 combinationally; PC, IR, IA and `fetch_count` hold; PS is ignored.
- When `IL`=0, `stall`=0 and the PC follows PS:
  - 00: hold.
  - 01: PC+4.
  - 10 or 11: load the target.
- Target selection:
  - PCsel=1: target = IA + (`constant` << 2), 64-bit wrap-around, carry discarded.
  - PCsel=0: target = `in`.
- Misaligned targets: if target[1:0] != 0, PC loads {target[63:2], 2'b00} and `align_fault` sets. It stays set until reset.
- Status: when `SL`=1, {V_r, C_r, N_r, Z_r} <- `alu_flags`; otherwise they hold. `status[0]` always follows `alu_flags[0]`.
- Stall priority: SL is still honoured while `stall`=1, since an in-flight flag update must not be lost.
- `fetch_count` wraps from 32'hFFFFFFFF to 0.
- Control is a two-state FSM:
  - READY --(IL & ~imem_ready)--> WAIT.
  - WAIT --(imem_ready)--> READY, completing the fetch that same cycle.
  - WAIT holds while `imem_ready`=0.
  - `stall` = IL & ~imem_ready in either state.

## Timing
- All registers update on the rising edge of `clock`; reset takes priority over every other input.
- Reset values:
  - PC = `RESET_PC`; IR = 0; IA = 0; flags = 0.
  - `align_fault` = 0; `fetch_count` = 0; FSM = READY.
- Combinational outputs after reset: `imem_addr` = `RESET_PC`, `PC4` = 4, `stall` = IL & ~imem_ready.
- Reset asserted during WAIT abandons the fetch: no IR update, and the next cycle fetches from `RESET_PC`.
- Fetch latency: the IR is visible the cycle after the edge where IL & imem_ready.
- Branch/PC update latency is 1 cycle. `imem_addr` shows the new PC after the edge.
- `stall`, `PC4`, `status[0]` and `imem_addr` have zero latency (combinational from registers/inputs).
- `IL` and PS=1x asserted in the same cycle with `imem_ready`=1: IR/IA load from the old PC and PC loads the target, where the target uses the old IA.

## Test plan
- Reset: assert `reset` 2 cycles with `RESET_PC`=64'h400 -> `imem_addr`=64'h400, `instruction`=0, `status`=5'b0 (Z_live=0), `fetch_count`=0, `align_fault`=0.
- Sequential fetch: IL=1, PS=01, `imem_ready`=1, data 32'h8B020020 -> `instruction`=32'h8B020020, IA=64'h400, PC=64'h404, `PC4`=64'h404, `fetch_count`=1.
- Wait states: IL=1, `imem_ready`=0 for 3 cycles, then 1 -> `stall`=1 for exactly those 3 cycles, PC holds at 64'h404, IR loads on cycle 4, `fetch_count`=2.
- Relative branch: IA=64'h404, PS=11, PCsel=1, `constant`=64'hFFFF_FFFF_FFFF_FFFF (-1) -> PC=64'h400. Repeat with `constant`=3 -> PC=64'h410.
- Register branch and fault: PS=10, PCsel=0, `in`=64'h1006 -> PC=64'h1004, `align_fault`=1 and still 1 after 5 further cycles. Only reset clears it.
- Status and wrap:
  - SL=1, `alu_flags`=4'b1001 during a stall -> `status`[4:1]=4'b1001.
  - `alu_flags`[0] toggling with SL=0 -> only `status[0]` follows.
  - Force `fetch_count`=32'hFFFFFFFF, then one fetch -> `fetch_count`=0.

Source files
------------

// File: rtl/pc_ir_fetch_unit.sv
// pc_ir_fetch_unit
//   Front end of the LEGv8 datapath. It holds the program counter (PC), the
//   instruction register (IR), the fetched-instruction address (IA) and the
//   registered condition flags. It also runs the instruction-memory ready
//   handshake.
//
// Ports
//   clock, reset     rising-edge clock, synchronous active-high reset
//   PS[1:0]          PC function: 00 hold, 01 PC+4, 1x load branch target
//   PCsel            target source: 0 = in, 1 = IA + (constant << 2)
//   IL, SL           instruction load (fetch) and status load requests
//   in[63:0]         register value used for BR/BLR/RET targets
//   constant[63:0]   sign-extended word offset
//   imem_data/ready  instruction word at imem_addr and its valid flag
//   alu_flags[3:0]   live ALU {V,C,N,Z}
//   imem_addr        current PC
//   instruction      IR
//   status[4:0]      {V_r,C_r,N_r,Z_r,Z_live}
//   PC4              IA + 4 (link value)
//   stall            fetch waiting on memory; freezes the control unit
//   align_fault      sticky flag, set by a misaligned branch target
//   fetch_count      number of completed fetches (wraps)
module pc_ir_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  PS,
  input  logic        PCsel,
  input  logic        IL,
  input  logic        SL,
  input  logic [63:0] in,
  input  logic [63:0] constant,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  input  logic [3:0]  alu_flags,
  output logic [63:0] imem_addr,
  output logic [31:0] instruction,
  output logic [4:0]  status,
  output logic [63:0] PC4,
  output logic        stall,
  output logic        align_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {ST_READY, ST_WAIT} state_t;

  state_t             state_p0, state_nxt;
  logic [63:0]        pc_p0, ia_p0;
  logic [31:0]        ir_p0;
  logic [3:0]         flags_p0;
  logic               fault_p0;
  logic [31:0]        fcnt_p0;

  logic               fetch_go;
  logic               pc_go;
  logic signed [63:0] offset;
  logic [63:0]        target;
  logic               target_bad;

  // Clear the two byte-offset bits so the PC always stays word aligned.
  function automatic logic [63:0] word_align(input logic [63:0] t);
    return t & ~64'd3;
  endfunction

  function automatic logic is_misaligned(input logic [63:0] t);
    return (t & 64'd3) != 64'd0;
  endfunction

  assign stall    = IL & ~imem_ready;
  assign fetch_go = IL & imem_ready;
  // PS applies whenever we are not stalled; a stalled fetch ignores PS.
  assign pc_go    = ~stall;

  // Relative targets use the address of the instruction now in the IR (the
  // old IA when a fetch and a branch share a cycle). The sum wraps at 64 bits.
  assign offset     = $signed(constant) <<< 2;
  assign target     = PCsel ? (ia_p0 + $unsigned(offset)) : in;
  assign target_bad = is_misaligned(target);

  // FSM: tracks an outstanding fetch; stall is the same in both states.
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_READY: if (IL && !imem_ready) state_nxt = ST_WAIT;
      ST_WAIT:  if (imem_ready)        state_nxt = ST_READY;
      default:                         state_nxt = ST_READY;
    endcase
  end

  // Stage p0: architectural state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0 <= ST_READY;
      pc_p0    <= RESET_PC;
      ia_p0    <= 64'd0;
      ir_p0    <= 32'd0;
      flags_p0 <= 4'd0;
      fault_p0 <= 1'b0;
      fcnt_p0  <= 32'd0;
    end else begin
      state_p0 <= state_nxt;
      if (fetch_go) begin
        ir_p0   <= imem_data;
        ia_p0   <= pc_p0;
        fcnt_p0 <= fcnt_p0 + 32'd1;
      end
      if (pc_go) begin
        case (PS)
          2'b00:   pc_p0 <= pc_p0;
          2'b01:   pc_p0 <= pc_p0 + 64'd4;
          default: begin
            pc_p0 <= word_align(target);
            if (target_bad) fault_p0 <= 1'b1;
          end
        endcase
      end
      // Flag updates go through even while stalled.
      if (SL) flags_p0 <= alu_flags;
    end
  end

  assign imem_addr   = pc_p0;
  assign instruction = ir_p0;
  assign status      = {flags_p0, alu_flags[0]};
  assign PC4         = ia_p0 + 64'd4;
  assign align_fault = fault_p0;
  assign fetch_count = fcnt_p0;

endmodule
